instruction_fetch_unit: RTL and testbench

//  Fetch stage directly downstream of the program counter register: takes the current PC,

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request at a time, PC tag capture,
// a small decode FIFO with registered head, and PC-register updates (sequential or redirect).
module instruction_fetch_unit #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned PC_LIMIT   = 2048
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] NewPC,
   output logic              WriteEnable,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] RedirectTarget,
   output logic              ImemReq,
   output logic [ADDR_W-1:0] ImemAddr,
   input  logic              ImemGnt,
   input  logic              ImemRvalid,
   input  logic [DATA_W-1:0] ImemRdata,
   output logic              InstrValid,
   output logic [DATA_W-1:0] Instr,
   output logic [ADDR_W-1:0] InstrPC,
   input  logic              DecodeReady
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state, state_nxt;
   logic              drop, drop_nxt;
   logic              tag_load;
   logic [ADDR_W-1:0] tag;
   logic              push, pop;
   logic [ADDR_W:0]   pc_plus4;
   logic [ADDR_W-1:0] seq_pc;

   entry_t            mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   entry_t            push_entry, head_nxt;

   // Sequential next PC, one bit wider so the limit compare cannot overflow
   assign pc_plus4 = {1'b0, PC} + (ADDR_W+1)'(4);
   assign seq_pc   = (pc_plus4 > (ADDR_W+1)'(PC_LIMIT)) ? '0 : pc_plus4[ADDR_W-1:0];
   assign ImemAddr = PC;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         drop  <= 1'b0;
         tag   <= '0;
      end else begin
         state <= state_nxt;
         drop  <= drop_nxt;
         if (tag_load) tag <= PC;
      end
   end

   // Request sequencing; a redirect overrides the PC update and flushes in-flight data
   always_comb begin
      state_nxt   = state;
      drop_nxt    = drop;
      ImemReq     = 1'b0;
      WriteEnable = 1'b0;
      NewPC       = '0;
      tag_load    = 1'b0;
      push        = 1'b0;
      case (state)
         IDLE: begin
            if (!Redirect && (count < CNT_W'(FIFO_DEPTH))) state_nxt = REQ;
         end
         REQ: begin
            ImemReq = 1'b1;
            if (ImemGnt) begin
               tag_load    = 1'b1;
               WriteEnable = 1'b1;
               NewPC       = seq_pc;
               state_nxt   = WAIT;
               if (Redirect) drop_nxt = 1'b1;
            end else if (Redirect) begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (ImemRvalid) begin
               push      = !drop && !Redirect;
               drop_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (Redirect) begin
               drop_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (Redirect) begin
         WriteEnable = 1'b1;
         NewPC       = RedirectTarget;
      end
   end

   assign pop = InstrValid && DecodeReady;

   // Next head: the freshly pushed word when the FIFO drains to empty this edge
   always_comb begin
      push_entry.data = ImemRdata;
      push_entry.pc   = tag;
      rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
      count_nxt       = count + CNT_W'(push) - CNT_W'(pop);
      head_nxt        = (count == CNT_W'(pop)) ? push_entry : mem[rd_ptr_nxt];
   end

   always_ff @(posedge Clock) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         InstrValid <= 1'b0;
         Instr      <= '0;
         InstrPC    <= '0;
      end else if (Redirect) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         InstrValid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr     <= rd_ptr_nxt;
         count      <= count_nxt;
         InstrValid <= (count_nxt != '0);
         if (count_nxt != '0) begin
            Instr   <= head_nxt.data;
            InstrPC <= head_nxt.pc;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: PC register, randomized memory responder, and an
// instruction-stream scoreboard derived from the fetch/redirect rules.
module tb_instruction_fetch_unit;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 2048;

   logic          Clock, Reset;
   logic [AW-1:0] PC, NewPC, RedirectTarget, ImemAddr, InstrPC;
   logic [DW-1:0] ImemRdata, Instr;
   logic          WriteEnable, Redirect, ImemReq, ImemGnt, ImemRvalid, InstrValid, DecodeReady;

   int n_cmp = 0, n_err = 0;
   int cfg_gnt_lo = 0, cfg_gnt_hi = 0, cfg_lat_lo = 0, cfg_lat_hi = 0;
   bit pending = 1'b0, in_req = 1'b0;
   int gnt_wait = 0, rsp_wait = 0;
   logic [AW-1:0] rsp_addr = '0;

   int acc_cnt = 0, gnt_total = 0, we_total = 0;
   logic [AW-1:0] exp_pc = '0, last_gnt_addr = '0, last_acc_pc = '0, prev_addr = '0;
   logic prev_req = 1'b0, prev_gnt = 1'b0, prev_redir = 1'b0, mon_exp_we;

   instruction_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .PC_LIMIT(LIMIT)) dut (
      .Clock(Clock), .Reset(Reset), .PC(PC), .NewPC(NewPC), .WriteEnable(WriteEnable),
      .Redirect(Redirect), .RedirectTarget(RedirectTarget), .ImemReq(ImemReq),
      .ImemAddr(ImemAddr), .ImemGnt(ImemGnt), .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
      .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC), .DecodeReady(DecodeReady));

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // PC register downstream of the fetch unit
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) PC <= '0;
      else if (WriteEnable) PC <= NewPC;
   end

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] p);
      logic [AW:0] s;
      s = {1'b0, p} + 33'd4;
      return (s > 33'(LIMIT)) ? '0 : s[AW-1:0];
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction memory: grant after a random delay, data after a random latency
   initial begin
      ImemGnt = 1'b0; ImemRvalid = 1'b0; ImemRdata = '0;
      forever begin
         @(negedge Clock);
         ImemGnt = 1'b0; ImemRvalid = 1'b0;
         if (!Reset) begin
            pending = 1'b0; in_req = 1'b0;
         end else if (pending) begin
            if (rsp_wait == 0) begin
               ImemRvalid = 1'b1; ImemRdata = mem_word(rsp_addr); pending = 1'b0;
            end else rsp_wait--;
         end else if (ImemReq) begin
            if (!in_req) begin
               in_req = 1'b1;
               gnt_wait = $urandom_range(cfg_gnt_hi, cfg_gnt_lo);
            end
            if (gnt_wait == 0) begin
               ImemGnt = 1'b1; in_req = 1'b0; pending = 1'b1; rsp_addr = ImemAddr;
               rsp_wait = $urandom_range(cfg_lat_hi, cfg_lat_lo);
            end else gnt_wait--;
         end else in_req = 1'b0;
      end
   end

   // Per-cycle protocol checks and in-order instruction-stream scoreboard
   initial begin
      forever begin
         @(negedge Clock); #2;
         if (!Reset) begin
            exp_pc = '0; prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0;
         end else begin
            if (ImemReq) chk32("imem_addr_tracks_pc", ImemAddr, PC);
            if (ImemReq && !ImemGnt) chk1("single_outstanding", pending, 1'b0);
            if (prev_req && !prev_gnt && !prev_redir) begin
               chk1("req_held", ImemReq, 1'b1);
               chk32("addr_held", ImemAddr, prev_addr);
            end
            mon_exp_we = Redirect || (ImemReq && ImemGnt);
            chk1("write_enable", WriteEnable, mon_exp_we);
            if (mon_exp_we) chk32("new_pc", NewPC, Redirect ? RedirectTarget : next_pc(PC));
            if (prev_redir) chk1("valid_after_flush", InstrValid, 1'b0);
            if (Redirect) exp_pc = RedirectTarget;
            else if (InstrValid && DecodeReady) begin
               chk32("instr_pc", InstrPC, exp_pc);
               chk32("instr_data", Instr, mem_word(exp_pc));
               exp_pc = next_pc(exp_pc);
               last_acc_pc = InstrPC;
               acc_cnt++;
            end
            if (ImemReq && ImemGnt) begin gnt_total++; last_gnt_addr = ImemAddr; end
            if (WriteEnable) we_total++;
            prev_req = ImemReq; prev_gnt = ImemGnt; prev_redir = Redirect; prev_addr = ImemAddr;
         end
      end
   end

   task automatic reset_checks();
      chk1("rst_imem_req", ImemReq, 1'b0);
      chk1("rst_write_enable", WriteEnable, 1'b0);
      chk32("rst_new_pc", NewPC, 32'h0);
      chk1("rst_instr_valid", InstrValid, 1'b0);
      chk32("rst_instr", Instr, 32'h0);
      chk32("rst_instr_pc", InstrPC, 32'h0);
      chk32("rst_imem_addr", ImemAddr, 32'h0);
   endtask

   task automatic wait_first_req(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge Clock); #3;
         found = ImemReq;
      end
      chk1({tag, "_seen"}, found, 1'b1);
      chk32(tag, ImemAddr, 32'h0);
   endtask

   task automatic wait_gnt_at(input logic [AW-1:0] addr, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge Clock); #3;
         found = ImemReq && ImemGnt && (ImemAddr == addr);
      end
      chk1(tag, found, 1'b1);
   endtask

   task automatic wait_new_grant(input logic [AW-1:0] addr, input string tag);
      int  g;
      bit  found = 1'b0;
      g = gnt_total;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge Clock); #3;
         found = (gnt_total != g);
      end
      chk1({tag, "_seen"}, found, 1'b1);
      chk32(tag, last_gnt_addr, addr);
   endtask

   task automatic wait_accept(input logic [AW-1:0] pc, input string tag);
      int a;
      bit found = 1'b0;
      a = acc_cnt;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge Clock); #3;
         found = (acc_cnt != a);
      end
      chk1({tag, "_seen"}, found, 1'b1);
      chk32(tag, last_acc_pc, pc);
   endtask

   initial begin
      int  a0, g0, we0;
      bit  found;
      logic prev;
      logic [AW-1:0] addr;
      Reset = 1'b0; Redirect = 1'b0; RedirectTarget = '0; DecodeReady = 1'b1;

      // Power-on reset
      repeat (2) @(negedge Clock);
      #3 reset_checks();
      @(negedge Clock) Reset = 1'b1;
      wait_first_req("first_addr_por");

      // Zero-wait memory, decode always ready: one instruction per three cycles
      repeat (6) @(negedge Clock);
      a0 = acc_cnt;
      repeat (30) @(negedge Clock);
      chk32("throughput_30cyc", 32'(acc_cnt - a0), 32'd10);

      // Reset asserted while a response is outstanding
      cfg_lat_lo = 2; cfg_lat_hi = 2;
      g0 = gnt_total;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge Clock); #3;
         found = (gnt_total != g0);
      end
      chk1("grant_before_reset", found, 1'b1);
      @(negedge Clock) Reset = 1'b0;
      #3 reset_checks();
      @(negedge Clock);
      cfg_lat_lo = 0; cfg_lat_hi = 0; DecodeReady = 1'b0;
      @(negedge Clock) Reset = 1'b1;
      g0 = gnt_total;
      wait_first_req("first_addr_after_reset");

      // Back-pressure: FIFO fills after exactly DEPTH fetches, then fetch stalls
      repeat (20) @(negedge Clock);
      chk32("bp_fetch_count", 32'(gnt_total - g0), 32'(DEPTH));
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock); #3;
         chk1("bp_req_low", ImemReq, 1'b0);
         chk1("bp_we_low", WriteEnable, 1'b0);
         chk1("bp_fifo_full_valid", InstrValid, 1'b1);
      end
      @(negedge Clock) DecodeReady = 1'b1;
      wait_new_grant(32'h8, "bp_resume_addr");

      // Redirect during WAIT for 0x10 with older words still buffered
      @(negedge Clock) Reset = 1'b0;
      @(negedge Clock) Reset = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge Clock); #3;
         found = (exp_pc == 32'hC);
      end
      chk1("reached_0x8", found, 1'b1);
      @(negedge Clock) DecodeReady = 1'b0;
      cfg_lat_lo = 3; cfg_lat_hi = 3;
      wait_gnt_at(32'h10, "grant_0x10");
      @(negedge Clock) begin Redirect = 1'b1; RedirectTarget = 32'h100; end
      #3;
      chk1("redir_we", WriteEnable, 1'b1);
      chk32("redir_new_pc", NewPC, 32'h100);
      chk1("redir_fifo_nonempty", InstrValid, 1'b1);
      @(negedge Clock) begin Redirect = 1'b0; DecodeReady = 1'b1; end
      cfg_lat_lo = 0; cfg_lat_hi = 0;
      #3 chk1("redir_flushed", InstrValid, 1'b0);
      wait_accept(32'h100, "redir_first_instr");

      // Wrap at the fetch limit
      @(negedge Clock) begin Redirect = 1'b1; RedirectTarget = 32'd2040; end
      @(negedge Clock) Redirect = 1'b0;
      wait_gnt_at(32'd2048, "grant_limit");
      chk1("wrap_we", WriteEnable, 1'b1);
      chk32("wrap_new_pc", NewPC, 32'h0);
      wait_new_grant(32'h0, "wrap_next_addr");

      // Grant delayed three cycles
      cfg_gnt_lo = 3; cfg_gnt_hi = 3;
      found = 1'b0; prev = ImemReq;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge Clock); #3;
         found = ImemReq && !prev;
         prev = ImemReq;
      end
      chk1("delayed_req_rise", found, 1'b1);
      addr = ImemAddr;
      we0 = we_total;
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clock); #3;
         chk1("delayed_req_held", ImemReq, 1'b1);
         chk32("delayed_addr_held", ImemAddr, addr);
         chk1("delayed_gnt", ImemGnt, (k == 3));
      end
      @(negedge Clock); #3;
      chk32("delayed_single_we", 32'(we_total - we0), 32'd1);

      // Randomized traffic: stalls, memory delays and occasional redirects
      cfg_gnt_lo = 0; cfg_gnt_hi = 3; cfg_lat_lo = 0; cfg_lat_hi = 3;
      a0 = acc_cnt;
      for (int i = 0; i < 1500; i++) begin
         @(negedge Clock);
         DecodeReady = ($urandom_range(3, 0) != 0);
         if (!Redirect && ($urandom_range(39, 0) == 0)) begin
            Redirect = 1'b1;
            RedirectTarget = 32'($urandom_range(512, 0)) * 32'd4;
         end else Redirect = 1'b0;
      end
      @(negedge Clock) begin Redirect = 1'b0; DecodeReady = 1'b1; end
      repeat (10) @(negedge Clock);
      chk1("random_progress", (acc_cnt - a0) >= 50, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
